// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache with critical-word capture and
// fixed-length line refill over a word-wide burst bus.
module icache_ctrl #(
  parameter int ADDR_W     = 64,
  parameter int INST_W     = 32,
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              req_valid_i,
  input  logic              wen_i,
  input  logic              flush_i,
  output logic [INST_W-1:0] data_o,
  output logic              data_valid_o,
  output logic              mem_req_valid_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_req_ready_i,
  input  logic [INST_W-1:0] mem_rdata_i,
  input  logic              mem_rdata_valid_i,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  localparam int WOFF_W = $clog2(LINE_WORDS);
  localparam int OFF    = WOFF_W + 2;
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_W - OFF - IDX_W;
  localparam logic [WOFF_W-1:0] LAST_BEAT = WOFF_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REFILL_REQ,
    S_REFILL,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0] r_addr;
  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [INST_W-1:0] r_data [LINES][LINE_WORDS];
  logic [WOFF_W-1:0] r_cnt;
  logic [INST_W-1:0] r_resp;
  logic [INST_W-1:0] r_data_o;
  logic              r_dvalid;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_hit_cnt;
  logic [31:0]       r_miss_cnt;
  logic              r_flushed;

  logic [WOFF_W-1:0] w_off;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit;
  logic              w_latch;
  logic              w_hit_ev;
  logic              w_miss_ev;
  logic              w_accept;
  logic              w_beat;
  logic              w_last;
  logic              w_unused;

  assign w_off    = r_addr[OFF-1:2];
  assign w_idx    = r_addr[OFF+IDX_W-1:OFF];
  assign w_tag    = r_addr[ADDR_W-1:OFF+IDX_W];
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_unused = &{1'b0, wen_i, r_addr[1:0]};

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_hit_ev    = 1'b0;
    w_miss_ev   = 1'b0;
    w_accept    = 1'b0;
    w_beat      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid_i) begin
          w_latch     = 1'b1;
          w_state_nxt = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (w_hit) begin
          w_hit_ev = 1'b1;
          if (req_valid_i) begin
            w_latch     = 1'b1;
            w_state_nxt = S_LOOKUP;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_miss_ev   = 1'b1;
          w_state_nxt = S_REFILL_REQ;
        end
      end
      S_REFILL_REQ: begin
        if (mem_req_ready_i) begin
          w_accept    = 1'b1;
          w_state_nxt = S_REFILL;
        end
      end
      S_REFILL: begin
        if (mem_rdata_valid_i) begin
          w_beat = 1'b1;
          if (r_cnt == LAST_BEAT) begin
            w_last      = 1'b1;
            w_state_nxt = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (req_valid_i) begin
          w_latch     = 1'b1;
          w_state_nxt = S_LOOKUP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr     <= '0;
      r_valid    <= '0;
      r_cnt      <= '0;
      r_resp     <= '0;
      r_data_o   <= '0;
      r_dvalid   <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_flushed  <= 1'b0;
    end else begin
      r_dvalid <= 1'b0;
      if (w_latch) r_addr <= addr_i;
      if (w_hit_ev) begin
        r_data_o <= r_data[w_idx][w_off];
        r_dvalid <= 1'b1;
        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if (w_miss_ev) begin
        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 32'd1;
        r_mem_addr <= {r_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
        r_mem_req  <= 1'b1;
        r_flushed  <= 1'b0;
      end
      if (w_accept) begin
        r_mem_req <= 1'b0;
        r_cnt     <= '0;
      end
      if (w_beat) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == w_off) r_resp <= mem_rdata_i;
      end
      // The critical word may be the last beat itself, so bypass r_resp then.
      if (w_last) begin
        r_data_o <= (r_cnt == w_off) ? mem_rdata_i : r_resp;
        r_dvalid <= 1'b1;
      end
      if (flush_i && (r_state == S_REFILL_REQ || r_state == S_REFILL))
        r_flushed <= 1'b1;
      if (flush_i)
        r_valid <= '0;
      else if (w_last && !r_flushed)
        r_valid[w_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && w_beat) r_data[w_idx][r_cnt] <= mem_rdata_i;
    if (rst && w_last) r_tag[w_idx] <= w_tag;
  end

  assign data_o          = r_data_o;
  assign data_valid_o    = r_dvalid;
  assign mem_req_valid_o = r_mem_req;
  assign mem_addr_o      = r_mem_addr;
  assign hit_cnt_o       = r_hit_cnt;
  assign miss_cnt_o      = r_miss_cnt;

endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: directed table, multi-cycle corner sequences and a
// randomized phase checked against a line-level cache model.
module tb_icache_ctrl;

  logic        clk;
  logic        rst;
  logic [63:0] addr_i;
  logic        req_valid_i;
  logic        wen_i;
  logic        flush_i;
  logic        fl_main;
  logic        fl_mem;
  logic [31:0] data_o;
  logic        data_valid_o;
  logic        mem_req_valid_o;
  logic [63:0] mem_addr_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_rdata_i;
  logic        mem_rdata_valid_i;
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;

  assign flush_i = fl_main | fl_mem;

  icache_ctrl #(.ADDR_W(64), .INST_W(32), .LINES(64), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst), .addr_i(addr_i), .req_valid_i(req_valid_i),
    .wen_i(wen_i), .flush_i(flush_i), .data_o(data_o), .data_valid_o(data_valid_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_addr_o(mem_addr_o),
    .mem_req_ready_i(mem_req_ready_i), .mem_rdata_i(mem_rdata_i),
    .mem_rdata_valid_i(mem_rdata_valid_i), .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  // memory responder configuration
  int          cfg_delay      = 0;
  bit          cfg_gap        = 0;
  bit          cfg_rgap       = 0;
  int          cfg_flush_beat = -1;
  logic [63:0] last_base      = '0;
  int          beats_sent     = 0;

  // line-level reference model
  logic [63:0] m_base [64];
  bit          m_val  [64];
  int          m_hits = 0;
  int          m_miss = 0;

  typedef struct {
    logic [63:0] addr;
    bit          flush_before;
    bit          exp_hit;
  } vec_t;
  vec_t tbl [9];

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [23:0] mix;
    mix = a[27:4] ^ a[59:36];
    return {mix, 8'h00} | (32'h11 * (32'(a[3:2]) + 32'd1));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit m_is_hit(input logic [63:0] a);
    return m_val[a[9:4]] && (m_base[a[9:4]] == (a & ~64'hF));
  endfunction

  task automatic m_clear(input bit counts);
    for (int i = 0; i < 64; i++) m_val[i] = 1'b0;
    if (counts) begin
      m_hits = 0;
      m_miss = 0;
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0;
    req_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_clear(1);
  endtask

  task automatic do_flush();
    @(negedge clk);
    fl_main = 1'b1;
    @(negedge clk);
    fl_main = 1'b0;
    m_clear(0);
  endtask

  // Issue one request at the current negedge and wait for its data_valid pulse.
  task automatic do_fetch(input logic [63:0] a, output logic [31:0] d, output int lat,
                          output bit ok);
    int t0;
    ok = 1'b0;
    d = '0;
    lat = 0;
    req_valid_i = 1'b1;
    addr_i = a;
    wen_i = 1'($urandom_range(0, 1));
    t0 = cyc;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      req_valid_i = 1'b0;
      addr_i = {$urandom, $urandom};
      if (data_valid_o) begin
        ok = 1'b1;
        d = data_o;
        lat = cyc - t0;
      end
    end
  endtask

  task automatic fetch_chk(input string nm, input logic [63:0] a, input bit exp_hit,
                           input bit install);
    logic [31:0] d;
    logic [31:0] m0;
    int lat;
    bit ok;
    m0 = miss_cnt_o;
    do_fetch(a, d, lat, ok);
    chk({nm, " done"}, 64'(ok), 64'd1);
    chk({nm, " data"}, 64'(d), 64'(mem_word(a & ~64'h3)));
    chk({nm, " miss"}, 64'(miss_cnt_o - m0), exp_hit ? 64'd0 : 64'd1);
    if (exp_hit) chk({nm, " hit latency"}, 64'(lat), 64'd2);
    if (exp_hit) m_hits++;
    else m_miss++;
    if (!exp_hit && install) begin
      m_val[a[9:4]]  = 1'b1;
      m_base[a[9:4]] = a & ~64'hF;
    end
  endtask

  // Memory responder: honours ready delay, beat gaps and flush injection.
  initial begin
    logic [63:0] base;
    int g;
    mem_req_ready_i   = 1'b0;
    mem_rdata_valid_i = 1'b0;
    mem_rdata_i       = '0;
    fl_mem            = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req_valid_o === 1'b1) begin
        base = mem_addr_o;
        last_base = base;
        for (int dl = 0; dl < cfg_delay; dl++) begin
          chk("bp req_valid", 64'(mem_req_valid_o), 64'd1);
          chk("bp addr", mem_addr_o, base);
          chk("bp data_valid", 64'(data_valid_o), 64'd0);
          @(negedge clk);
        end
        mem_req_ready_i = 1'b1;
        @(negedge clk);
        mem_req_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
          g = 0;
          if (cfg_gap && k > 0) g = 1;
          if (cfg_rgap) g = $urandom_range(0, 2);
          repeat (g) @(negedge clk);
          mem_rdata_valid_i = 1'b1;
          mem_rdata_i = mem_word(base + 64'(4 * k));
          if (k == cfg_flush_beat) fl_mem = 1'b1;
          beats_sent++;
          @(negedge clk);
          mem_rdata_valid_i = 1'b0;
          fl_mem = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: cycle %0d reached, required completion earlier", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    int lat, s, to, dv;
    bit ok;

    tbl[0] = '{64'h8000_0000, 1'b0, 1'b0};
    tbl[1] = '{64'h8000_0400, 1'b0, 1'b0};
    tbl[2] = '{64'h8000_0000, 1'b0, 1'b0};
    tbl[3] = '{64'h8000_0008, 1'b0, 1'b1};
    tbl[4] = '{64'h8000_0000, 1'b1, 1'b0};
    tbl[5] = '{64'h8000_0014, 1'b0, 1'b0};
    tbl[6] = '{64'h8000_001C, 1'b0, 1'b1};
    tbl[7] = '{64'h8000_0403, 1'b0, 1'b0};
    tbl[8] = '{64'h8000_0401, 1'b0, 1'b1};

    rst = 1'b0;
    addr_i = '0;
    req_valid_i = 1'b0;
    wen_i = 1'b0;
    fl_main = 1'b0;
    m_clear(1);
    repeat (3) @(negedge clk);
    chk("reset data_o", 64'(data_o), 64'd0);
    chk("reset data_valid", 64'(data_valid_o), 64'd0);
    chk("reset mem_req", 64'(mem_req_valid_o), 64'd0);
    chk("reset mem_addr", mem_addr_o, 64'd0);
    chk("reset hit_cnt", 64'(hit_cnt_o), 64'd0);
    chk("reset miss_cnt", 64'(miss_cnt_o), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // cold miss then three back-to-back hits
    do_fetch(64'h8000_0000, d, lat, ok);
    chk("cold done", 64'(ok), 64'd1);
    chk("cold base", last_base, 64'h8000_0000);
    chk("cold data", 64'(d), 64'h11);
    chk("cold latency", 64'(lat), 64'd7);
    req_valid_i = 1'b1;
    addr_i = 64'h8000_0004;
    @(negedge clk);
    chk("b2b lookup gap", 64'(data_valid_o), 64'd0);
    addr_i = 64'h8000_0008;
    @(negedge clk);
    chk("b2b v1", 64'(data_valid_o), 64'd1);
    chk("b2b d1", 64'(data_o), 64'h22);
    addr_i = 64'h8000_000C;
    @(negedge clk);
    chk("b2b v2", 64'(data_valid_o), 64'd1);
    chk("b2b d2", 64'(data_o), 64'h33);
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("b2b v3", 64'(data_valid_o), 64'd1);
    chk("b2b d3", 64'(data_o), 64'h44);
    @(negedge clk);
    chk("b2b end", 64'(data_valid_o), 64'd0);
    chk("b2b hit_cnt", 64'(hit_cnt_o), 64'd3);
    chk("b2b miss_cnt", 64'(miss_cnt_o), 64'd1);

    // critical word at offset 3 with gapped beats
    cfg_gap = 1'b1;
    do_fetch(64'h8000_002C, d, lat, ok);
    chk("crit done", 64'(ok), 64'd1);
    chk("crit data", 64'(d), 64'h244);
    chk("crit latency", 64'(lat), 64'd10);
    dv = 0;
    repeat (4) begin
      @(negedge clk);
      if (data_valid_o) dv++;
    end
    chk("crit single pulse", 64'(dv), 64'd0);
    cfg_gap = 1'b0;

    // table: conflict eviction, flush, low address bits ignored
    reset_dut();
    foreach (tbl[i]) begin
      if (tbl[i].flush_before) do_flush();
      fetch_chk($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].exp_hit, 1'b1);
      if (i == 2) chk("evict miss_cnt", 64'(miss_cnt_o), 64'd3);
    end
    chk("tbl hit_cnt", 64'(hit_cnt_o), 64'(m_hits));
    chk("tbl miss_cnt", 64'(miss_cnt_o), 64'(m_miss));

    // flush during refill, and flush coinciding with the last beat
    cfg_flush_beat = 1;
    m_clear(0);
    fetch_chk("flref", 64'h8000_0100, 1'b0, 1'b0);
    cfg_flush_beat = -1;
    fetch_chk("flref refetch", 64'h8000_0104, 1'b0, 1'b1);
    cfg_flush_beat = 3;
    m_clear(0);
    fetch_chk("fllast", 64'h8000_0200, 1'b0, 1'b0);
    cfg_flush_beat = -1;
    fetch_chk("fllast refetch", 64'h8000_0208, 1'b0, 1'b1);
    fetch_chk("fllast hit", 64'h8000_020C, 1'b1, 1'b1);

    // reset after two beats of a refill
    s = beats_sent;
    req_valid_i = 1'b1;
    addr_i = 64'h8000_0300;
    @(negedge clk);
    req_valid_i = 1'b0;
    to = 0;
    while (beats_sent < s + 2 && to < 100) begin
      @(negedge clk);
      to++;
    end
    chk("rst beats wait", 64'(to < 100), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst data_o", 64'(data_o), 64'd0);
    chk("midrst data_valid", 64'(data_valid_o), 64'd0);
    chk("midrst mem_req", 64'(mem_req_valid_o), 64'd0);
    chk("midrst mem_addr", mem_addr_o, 64'd0);
    chk("midrst hit_cnt", 64'(hit_cnt_o), 64'd0);
    chk("midrst miss_cnt", 64'(miss_cnt_o), 64'd0);
    rst = 1'b1;
    m_clear(1);
    dv = 0;
    to = 0;
    while (beats_sent < s + 4 && to < 100) begin
      @(negedge clk);
      if (data_valid_o) dv++;
      to++;
    end
    repeat (3) begin
      @(negedge clk);
      if (data_valid_o || mem_req_valid_o) dv++;
    end
    chk("midrst beats ignored", 64'(dv), 64'd0);
    fetch_chk("midrst refetch", 64'h8000_0300, 1'b0, 1'b1);
    chk("midrst miss_cnt after", 64'(miss_cnt_o), 64'd1);

    // memory backpressure
    cfg_delay = 5;
    do_fetch(64'h8000_0500, d, lat, ok);
    chk("bp done", 64'(ok), 64'd1);
    chk("bp base", last_base, 64'h8000_0500);
    chk("bp data", 64'(d), 64'(mem_word(64'h8000_0500)));
    chk("bp latency", 64'(lat), 64'd12);
    m_miss++;
    m_val[6'h10]  = 1'b1;
    m_base[6'h10] = 64'h8000_0500;
    cfg_delay = 0;

    // randomized traffic over a small set of conflicting lines
    for (int i = 0; i < 200; i++) begin
      logic [63:0] a;
      case ($urandom_range(0, 2))
        0:       a = 64'h8000_0000;
        1:       a = 64'h8000_0400;
        default: a = 64'hDEAD_BEEF_0000_0000;
      endcase
      a = a | (64'($urandom_range(0, 3)) << 4) | (64'($urandom_range(0, 3)) << 2)
            | 64'($urandom_range(0, 3));
      cfg_delay = $urandom_range(0, 2);
      cfg_rgap  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 8) do_flush();
      fetch_chk("rand", a, m_is_hit(a), 1'b1);
    end
    chk("final hit_cnt", 64'(hit_cnt_o), 64'(m_hits));
    chk("final miss_cnt", 64'(miss_cnt_o), 64'(m_miss));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
Direct-mapped, read-only instruction cache between the core's fetch port and a simple word-wide memory bus. It accepts fetch addresses from PC, returns one 32-bit instruction per request with a valid strobe, and refills missing lines as a fixed-length burst. CTRL stalls the pipeline on data_valid low.

Parameters:
ADDR_W, 64, fetch/memory address width
INST_W, 32, instruction and memory beat width
LINES, 64, number of cache lines (power of 2)
LINE_WORDS, 4, 32-bit words per line (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-low
addr_i  in  ADDR_W  fetch address from PC
req_valid_i  in  1  fetch request
wen_i  in  1  write enable from PC; ignored, the cache is read-only
flush_i  in  1  invalidate all lines
data_o  out  INST_W  instruction to IF_ID
data_valid_o  out  1  data_o valid this cycle
mem_req_valid_o  out  1  burst request to memory
mem_addr_o  out  ADDR_W  line-aligned burst base address
mem_req_ready_i  in  1  memory accepts the request
mem_rdata_i  in  INST_W  burst beat data
mem_rdata_valid_i  in  1  beat valid
hit_cnt_o  out  32  hit counter
miss_cnt_o  out  32  miss counter

Behaviour:
- Address split: offset = addr[OFF-1:2], where OFF = log2(LINE_WORDS)+2. index = next log2(LINES) bits. tag = remaining upper bits. addr[1:0] is ignored.
- Reset (rst==0 at a clk edge):
  - All valid bits cleared.
  - State goes to IDLE.
  - data_o=0, data_valid_o=0, mem_req_valid_o=0, mem_addr_o=0, counters=0.
  - The beat counter is cleared. Any beats still arriving afterwards are ignored.
- States: IDLE, LOOKUP, REFILL_REQ, REFILL, RESP.
- IDLE:
  - If req_valid_i: latch addr_i, read the tag/data arrays, go to LOOKUP. Otherwise stay.
- LOOKUP:
  - Hit (valid && tag match):
    - data_o = word[offset] and data_valid_o=1 for exactly one cycle, registered.
    - hit_cnt_o += 1.
    - If req_valid_i is high in the same cycle, latch the new address and stay in LOOKUP. Otherwise go to IDLE.
    - Back-to-back hits therefore sustain 1 instruction/cycle after 1-cycle latency.
  - Miss:
    - miss_cnt_o += 1.
    - mem_addr_o = {addr[ADDR_W-1:OFF], OFF'b0}.
    - Go to REFILL_REQ.
- REFILL_REQ:
  - mem_req_valid_o=1. mem_addr_o is held stable until mem_req_ready_i.
  - On ready: drop valid the next cycle, clear the beat counter, go to REFILL.
- REFILL:
  - Each cycle with mem_rdata_valid_i: write mem_rdata_i to word[cnt] of the indexed line, cnt += 1.
  - When cnt==offset, capture the beat as the response word.
  - Beats may have gaps (valid low).
  - On the last beat (cnt==LINE_WORDS-1): write the tag, set valid, go to RESP.
- RESP:
  - data_o = captured word, data_valid_o=1 for one cycle.
  - If req_valid_i: latch and go to LOOKUP. Otherwise go to IDLE.
- The requesting address is held internally. Changes on addr_i during a miss do not affect the pending response.
- flush_i:
  - Clears all valid bits at the clk edge.
  - In LOOKUP, a flush in the same cycle as a hit still returns that hit.
  - During REFILL_REQ/REFILL, the refill completes and the response is delivered, but the line is NOT marked valid.
  - flush_i and a last beat in the same cycle: the line stays invalid.
- Counters saturate at 32'hFFFFFFFF; they do not wrap.
- Miss latency from the request edge: 1 (lookup) + handshake + LINE_WORDS beats + 1 (resp).

Test Plan:
- Cold miss, then sequential hits:
  - Stimulus: reset, then req addr 0x80000000. Memory returns 0x11,0x22,0x33,0x44 with ready immediately.
  - Required: mem_req at base 0x80000000; data_o=0x11 in RESP.
  - Then 0x80000004/8/C back-to-back return 0x22/0x33/0x44 on consecutive cycles. hit_cnt=3, miss_cnt=1.
- Critical word mid-line:
  - Stimulus: req 0x8000002C (offset 3) with gapped beats (valid every other cycle).
  - Required: response = 4th beat, exactly one data_valid pulse after the last beat.
- Conflict eviction:
  - Stimulus: fetch 0x80000000, then 0x80000400 (same index, LINES=64), then 0x80000000.
  - Required: three misses, miss_cnt=3, correct data each time.
- Flush:
  - Stimulus: flush_i after line 0x80000000 is filled.
  - Required: the next fetch misses.
  - Flush asserted during REFILL: data is returned, but a refetch of the same address misses again.
- Reset mid-refill:
  - Stimulus: rst=0 for one cycle after 2 beats.
  - Required: all outputs 0, state IDLE, remaining beats ignored, the next fetch of the same line misses.
- Backpressure:
  - Stimulus: hold mem_req_ready_i=0 for 5 cycles.
  - Required: mem_req_valid_o and mem_addr_o stay stable and data_valid_o stays 0 until the burst completes.
